// File: rtl/ac97_seq_pkg.sv
// ----------------------------------------------------------------------------
// ac97_seq_pkg
// Shared types and constants for the AC'97 codec command sequencer:
//   - seq_state_t : sequencer FSM states
//   - REG_*       : AC'97 codec register indices touched by the init table
//   - CMD_COUNT   : number of entries in the init table
//   - IDX_W       : width of the table index
//   - cmd_entry_t : one table entry {addr[6:0], data[15:0]}
// ----------------------------------------------------------------------------
package ac97_seq_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RST_HOLD   = 3'd1,
        WAIT_READY = 3'd2,
        ISSUE      = 3'd3,
        READBACK   = 3'd4,
        WAIT_RSP   = 3'd5,
        DONE       = 3'd6,
        ERROR      = 3'd7
    } seq_state_t;

    // Codec register indices used by the init table
    localparam logic [6:0] REG_MASTER_VOL     = 7'h02;
    localparam logic [6:0] REG_PCM_OUT_VOL    = 7'h18;
    localparam logic [6:0] REG_RECORD_SELECT  = 7'h1A;
    localparam logic [6:0] REG_EXT_AUDIO_CTRL = 7'h2A;
    localparam logic [6:0] REG_PCM_DAC_RATE   = 7'h2C;
    localparam logic [6:0] REG_PCM_ADC_RATE   = 7'h32;

    localparam int CMD_COUNT = 6;
    localparam int IDX_W     = $clog2(CMD_COUNT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CMD_COUNT - 1);

    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] data;
    } cmd_entry_t;

endpackage

// File: rtl/ac97_cmd_rom.sv
// ----------------------------------------------------------------------------
// ac97_cmd_rom
// Combinational codec init table: index -> {register, write data}.
// Enables variable rate audio, sets both sample rates to 48 kHz, unmutes the
// master and PCM outputs, and selects the mic as record source.
// Ports:
//   idx_i   [IDX_W-1:0]  table index
//   entry_o cmd_entry_t  table entry (all zero past the end of the table)
// ----------------------------------------------------------------------------
module ac97_cmd_rom
    import ac97_seq_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    output cmd_entry_t       entry_o
);

    always_comb begin
        entry_o = '0;
        case (idx_i)
            IDX_W'(0): entry_o = {REG_EXT_AUDIO_CTRL, 16'h0001};
            IDX_W'(1): entry_o = {REG_PCM_DAC_RATE,   16'hBB80};
            IDX_W'(2): entry_o = {REG_PCM_ADC_RATE,   16'hBB80};
            IDX_W'(3): entry_o = {REG_MASTER_VOL,     16'h0000};
            IDX_W'(4): entry_o = {REG_PCM_OUT_VOL,    16'h0808};
            IDX_W'(5): entry_o = {REG_RECORD_SELECT,  16'h0000};
            default:   entry_o = '0;
        endcase
    end

endmodule

// File: rtl/ac97_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// ac97_cmd_sequencer
// Cold-resets an AC'97 codec, waits for codec-ready, then writes the init
// table (ac97_cmd_rom) to the frame engine one command per handshake.
// Optional feature macro: AC97_SEQ_READBACK_EN -- every accepted write is
// followed by a read of the same register and the returned data is compared.
// Ports:
//   SYS_CLK, SYS_RST_N         clock, asynchronous active-low reset
//   start                      one-cycle pulse, (re)runs the sequence when idle
//   codec_ready                codec-ready tag from the frame engine
//   audio_reset_b              AC'97 cold reset (active low)
//   cmd_valid/cmd_ready        command handshake; cmd_rw 1 = read
//   cmd_addr[6:0], cmd_data    command register index / write data
//   rsp_valid/rsp_addr/rsp_data status slot return (readback build only)
//   busy, done, error          sequencer status
// ----------------------------------------------------------------------------
module ac97_cmd_sequencer
    import ac97_seq_pkg::*;
#(
    parameter int RESET_CYCLES  = 100,
    parameter int READY_TIMEOUT = 24000,
    parameter int RSP_TIMEOUT   = 4096
) (
    input  logic        SYS_CLK,
    input  logic        SYS_RST_N,
    input  logic        start,
    input  logic        codec_ready,
    output logic        audio_reset_b,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_rw,
    output logic [6:0]  cmd_addr,
    output logic [15:0] cmd_data,
    input  logic        rsp_valid,
    input  logic [6:0]  rsp_addr,
    input  logic [15:0] rsp_data,
    output logic        busy,
    output logic        done,
    output logic        error
);

    // One shared cycle counter serves all timed states
    localparam int CNT_MAX_A = (RESET_CYCLES > READY_TIMEOUT) ? RESET_CYCLES : READY_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > RSP_TIMEOUT) ? CNT_MAX_A : RSP_TIMEOUT;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] RDY_LAST = CNT_W'(READY_TIMEOUT - 1);

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gap_q, gap_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             cmd_fire;
    cmd_entry_t       entry;

    ac97_cmd_rom u_rom (
        .idx_i   (idx_q),
        .entry_o (entry)
    );

    // Saturating increment: the counter never wraps back to zero
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign cmd_fire = cmd_valid & cmd_ready;

`ifdef AC97_SEQ_READBACK_EN
    localparam logic [CNT_W-1:0] RSP_LAST = CNT_W'(RSP_TIMEOUT - 1);
    logic rsp_match;
    assign rsp_match = rsp_valid && (rsp_addr == entry.addr);
`else
    logic unused_rsp;
    assign unused_rsp = ^{rsp_valid, rsp_addr, rsp_data};
`endif

    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        gap_d   = 1'b0;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d = RST_HOLD;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            RST_HOLD: begin
                if (cnt_q >= RST_LAST) begin
                    state_d = WAIT_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WAIT_READY: begin
                if (codec_ready) begin
                    state_d = ISSUE;
                    cnt_d   = '0;
                end else if (cnt_q >= RDY_LAST) begin
                    state_d = ERROR;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ISSUE: begin
                // Losing codec-ready wins over a same-cycle acceptance
                if (!codec_ready) begin
                    state_d = ERROR;
                end else if (cmd_fire) begin
`ifdef AC97_SEQ_READBACK_EN
                    state_d = READBACK;
                    gap_d   = 1'b1;
`else
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        gap_d = 1'b1;
                    end
`endif
                end
            end
`ifdef AC97_SEQ_READBACK_EN
            READBACK: begin
                if (!codec_ready) begin
                    state_d = ERROR;
                end else if (cmd_fire) begin
                    state_d = WAIT_RSP;
                    cnt_d   = '0;
                end
            end
            WAIT_RSP: begin
                if (!codec_ready) begin
                    state_d = ERROR;
                end else if (rsp_match) begin
                    if (rsp_data != entry.data) begin
                        state_d = ERROR;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end else if (cnt_q >= RSP_LAST) begin
                    state_d = ERROR;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from registered state only, so an asynchronous
    // reset forces them to their idle values immediately.
    always_comb begin
        audio_reset_b = !((state_q == IDLE) || (state_q == RST_HOLD));
        busy          = (state_q == RST_HOLD) || (state_q == WAIT_READY) ||
                        (state_q == ISSUE) || (state_q == READBACK) ||
                        (state_q == WAIT_RSP);
        done          = (state_q == DONE);
        error         = (state_q == ERROR);
        // gap_q blanks cmd_valid for the cycle right after an acceptance
        cmd_valid     = ((state_q == ISSUE) || (state_q == READBACK)) && !gap_q;
        cmd_rw        = (state_q == READBACK);
        cmd_addr      = '0;
        cmd_data      = '0;
        if ((state_q == ISSUE) || (state_q == READBACK) || (state_q == WAIT_RSP)) begin
            cmd_addr = entry.addr;
        end
        if (state_q == ISSUE) begin
            cmd_data = entry.data;
        end
    end

endmodule
